// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multicycle LEGv8 control unit. Accepts one 11-bit opcode per valid/ready
//   handshake in IDLE and walks it through EXEC, then MEM/WB/BRANCH, driving
//   the datapath controls from the current state and the latched instruction
//   class. A data-memory access that sees no dmem_ready for MEM_TIMEOUT
//   consecutive cycles parks the FSM in FAULT until reset.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   instruction[10:0]     opcode field [31:21], sampled on valid && ready
//   instr_valid           opcode present
//   instr_ready           high only in IDLE
//   dmem_ready            data memory finished the current access
//   reg2loc .. branch     datapath control strobes
//   alu_op[1:0]           00 add (address), 01 pass-b/compare, 10 funct
//   is_*_branch           branch flavour, asserted in BRANCH only
//   illegal_op            one-cycle pulse after an unrecognised opcode is accepted
//   fault                 sticky memory-timeout flag
//   instr_retired         wrapping count of completed instructions
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4,
  parameter int CNT_W       = 16,
  parameter int IMM_EN      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             dmem_ready,
  output logic             reg2loc,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem2reg,
  output logic             branch,
  output logic [1:0]       alu_op,
  output logic             is_zero_branch,
  output logic             is_nonzero_branch,
  output logic             is_uncon_branch,
  output logic             illegal_op,
  output logic             fault,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] EXEC   = 3'd1;
  localparam logic [2:0] MEM    = 3'd2;
  localparam logic [2:0] WB     = 3'd3;
  localparam logic [2:0] BRANCH = 3'd4;
  localparam logic [2:0] FAULT  = 3'd5;

  // Instruction classes; only the class is kept after acceptance since
  // every later control decision depends on nothing finer.
  localparam logic [2:0] C_R    = 3'd0;
  localparam logic [2:0] C_I    = 3'd1;
  localparam logic [2:0] C_LD   = 3'd2;
  localparam logic [2:0] C_ST   = 3'd3;
  localparam logic [2:0] C_CBZ  = 3'd4;
  localparam logic [2:0] C_CBNZ = 3'd5;
  localparam logic [2:0] C_B    = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  logic [2:0]           state;
  logic [2:0]           cls;
  logic [2:0]           inCls;
  logic [TIMEOUT_W-1:0] waitCnt;
  logic                 illegalQ;

  always_comb begin
    inCls = C_ILL;
    if (instruction == 11'b10001011000 || instruction == 11'b11001011000 ||
        instruction == 11'b10001010000 || instruction == 11'b10101010000)
      inCls = C_R;
    else if (IMM_EN != 0 && (instruction[10:1] == 10'b1001000100 ||
                             instruction[10:1] == 10'b1101000100))
      inCls = C_I;
    else if (instruction == 11'b11111000010)
      inCls = C_LD;
    else if (instruction == 11'b11111000000)
      inCls = C_ST;
    else if (instruction[10:3] == 8'b10110100)
      inCls = C_CBZ;
    else if (instruction[10:3] == 8'b10110101)
      inCls = C_CBNZ;
    else if (instruction[10:5] == 6'b000101)
      inCls = C_B;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cls           <= C_R;
      waitCnt       <= '0;
      illegalQ      <= 1'b0;
      instr_retired <= '0;
    end else begin
      illegalQ <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (inCls == C_ILL) begin
              illegalQ <= 1'b1;
            end else begin
              cls   <= inCls;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          case (cls)
            C_R, C_I: state <= WB;
            C_LD, C_ST: begin
              state   <= MEM;
              waitCnt <= '0;
            end
            default: state <= BRANCH;
          endcase
        end
        MEM: begin
          if (dmem_ready) begin
            if (cls == C_LD) begin
              state <= WB;
            end else begin
              state         <= IDLE;
              instr_retired <= instr_retired + CNT_W'(1);
            end
          end else if (waitCnt == TIMEOUT_W'(MEM_TIMEOUT - 1)) begin
            // This is the MEM_TIMEOUT-th consecutive cycle without ready.
            state <= FAULT;
          end else begin
            waitCnt <= waitCnt + TIMEOUT_W'(1);
          end
        end
        WB, BRANCH: begin
          state         <= IDLE;
          instr_retired <= instr_retired + CNT_W'(1);
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    reg2loc           = 1'b0;
    alu_src           = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    reg_write         = 1'b0;
    mem2reg           = 1'b0;
    branch            = 1'b0;
    alu_op            = 2'b00;
    is_zero_branch    = 1'b0;
    is_nonzero_branch = 1'b0;
    is_uncon_branch   = 1'b0;
    case (state)
      EXEC: begin
        case (cls)
          C_R: alu_op = 2'b10;
          C_I: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
          end
          C_LD: alu_src = 1'b1;
          C_ST: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
          end
          C_CBZ, C_CBNZ: begin
            alu_op  = 2'b01;
            reg2loc = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        alu_src = 1'b1;
        if (cls == C_LD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          reg2loc   = 1'b1;
        end
      end
      WB: begin
        reg_write = 1'b1;
        mem2reg   = (cls == C_LD);
        if (cls == C_R || cls == C_I) alu_op = 2'b10;
        if (cls == C_I) alu_src = 1'b1;
      end
      BRANCH: begin
        branch            = 1'b1;
        is_zero_branch    = (cls == C_CBZ);
        is_nonzero_branch = (cls == C_CBNZ);
        is_uncon_branch   = (cls == C_B);
      end
      default: ;
    endcase
  end

  assign instr_ready = (state == IDLE);
  assign fault       = (state == FAULT);
  assign illegal_op  = illegalQ;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Drives directed and random opcodes into multicycle_controller (CNT_W=4 so
//   the retire counter wraps quickly) and compares every cycle's control
//   vector and retire count against per-instruction expected sequences built
//   from the instruction-class rules.
module tb_multicycle_controller;

  localparam int TMO = 15;
  localparam int CW  = 4;

  // Bit positions in the packed control vector.
  localparam int RDY = 14, R2L = 13, ASRC = 12, MRD = 11, MWR = 10, RW = 9,
                 M2R = 8, BR = 7, AOP1 = 6, AOP0 = 5, ZB = 4, NZB = 3,
                 UB = 2, ILL = 1, FLT = 0;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_CBNZ = 5,
                 K_B = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic          dmem_ready;
  logic          reg2loc, alu_src, mem_read, mem_write, reg_write, mem2reg, branch;
  logic [1:0]    alu_op;
  logic          is_zero_branch, is_nonzero_branch, is_uncon_branch;
  logic          illegal_op, fault;
  logic [CW-1:0] instr_retired;
  logic [14:0]   obs;

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] modelCnt;
  logic [14:0]   expQ[$];
  int            phQ[$];   // 0 = don't care dmem_ready, 1 = hold low, 2 = raise

  multicycle_controller #(
    .MEM_TIMEOUT(TMO),
    .TIMEOUT_W(4),
    .CNT_W(CW),
    .IMM_EN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .dmem_ready(dmem_ready),
    .reg2loc(reg2loc),
    .alu_src(alu_src),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .mem2reg(mem2reg),
    .branch(branch),
    .alu_op(alu_op),
    .is_zero_branch(is_zero_branch),
    .is_nonzero_branch(is_nonzero_branch),
    .is_uncon_branch(is_uncon_branch),
    .illegal_op(illegal_op),
    .fault(fault),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  assign obs = {instr_ready, reg2loc, alu_src, mem_read, mem_write, reg_write,
                mem2reg, branch, alu_op, is_zero_branch, is_nonzero_branch,
                is_uncon_branch, illegal_op, fault};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [14:0] idleVec(input logic ill);
    logic [14:0] e;
    e      = '0;
    e[RDY] = 1'b1;
    e[ILL] = ill;
    return e;
  endfunction

  function automatic logic [10:0] makeOp(input int kind);
    logic [10:0] r;
    r = 11'($urandom);
    case (kind)
      K_R: begin
        case ($urandom_range(0, 3))
          0:       r = 11'b10001011000;
          1:       r = 11'b11001011000;
          2:       r = 11'b10001010000;
          default: r = 11'b10101010000;
        endcase
      end
      K_I:    r = {($urandom_range(0, 1) == 0) ? 10'b1001000100 : 10'b1101000100, r[0]};
      K_LD:   r = 11'b11111000010;
      K_ST:   r = 11'b11111000000;
      K_CBZ:  r = {8'b10110100, r[2:0]};
      K_CBNZ: r = {8'b10110101, r[2:0]};
      default: r = {6'b000101, r[4:0]};
    endcase
    return r;
  endfunction

  function automatic bit isLegal(input logic [10:0] op);
    logic [10:0] msk[10];
    logic [10:0] val[10];
    msk = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF,
            11'h7FE, 11'h7FE, 11'h7F8, 11'h7E0};
    val = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
            11'b11111000010, 11'b11111000000, 11'b10010001000, 11'b11010001000,
            11'b10110100000, 11'b00010100000};
    for (int i = 0; i < 10; i++)
      if ((op & msk[i]) == val[i]) return 1'b1;
    // CBNZ shares the CBZ mask with a different value.
    if ((op & 11'h7F8) == 11'b10110101000) return 1'b1;
    return 1'b0;
  endfunction

  // Expected per-cycle controls after acceptance, from the class rules.
  task automatic buildSeq(input int kind, input int waits);
    logic [14:0] e;
    e = '0;
    case (kind)
      K_R:  e[AOP1] = 1'b1;
      K_I:  begin e[AOP1] = 1'b1; e[ASRC] = 1'b1; end
      K_LD: e[ASRC] = 1'b1;
      K_ST: begin e[ASRC] = 1'b1; e[R2L] = 1'b1; end
      K_CBZ, K_CBNZ: begin e[AOP0] = 1'b1; e[R2L] = 1'b1; end
      default: ;
    endcase
    expQ.push_back(e);
    phQ.push_back(0);
    if (kind == K_LD || kind == K_ST) begin
      for (int i = 0; i <= waits; i++) begin
        e = '0;
        e[ASRC] = 1'b1;
        if (kind == K_LD) e[MRD] = 1'b1;
        else begin e[MWR] = 1'b1; e[R2L] = 1'b1; end
        expQ.push_back(e);
        phQ.push_back((i < waits) ? 1 : 2);
      end
    end
    if (kind == K_R || kind == K_I || kind == K_LD) begin
      e = '0;
      e[RW]  = 1'b1;
      e[M2R] = (kind == K_LD);
      if (kind != K_LD) e[AOP1] = 1'b1;
      if (kind == K_I) e[ASRC] = 1'b1;
      expQ.push_back(e);
      phQ.push_back(0);
    end
    if (kind >= K_CBZ) begin
      e = '0;
      e[BR]  = 1'b1;
      e[ZB]  = (kind == K_CBZ);
      e[NZB] = (kind == K_CBNZ);
      e[UB]  = (kind == K_B);
      expQ.push_back(e);
      phQ.push_back(0);
    end
  endtask

  // Walk up to n queued cycles, checking each at the negedge; busy-time
  // instr_valid/instruction are random and must be ignored.
  task automatic runSeq(input int n);
    logic [14:0] e;
    int          ph;
    int          k;
    k = 0;
    while (expQ.size() > 0 && k < n) begin
      e  = expQ.pop_front();
      ph = phQ.pop_front();
      check("ctl", 16'(obs), 16'(e));
      check("cnt", 16'(instr_retired), 16'(modelCnt));
      instr_valid = 1'($urandom);
      instruction = 11'($urandom);
      dmem_ready  = (ph == 1) ? 1'b0 : (ph == 2) ? 1'b1 : 1'($urandom);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic acceptOp(input logic [10:0] op);
    instruction = op;
    instr_valid = 1'b1;
    dmem_ready  = 1'($urandom);
    @(negedge clk);
  endtask

  // Entry and exit: just after a negedge with the DUT idle.
  task automatic runInstr(input int kind, input int waits);
    buildSeq(kind, waits);
    acceptOp(makeOp(kind));
    runSeq(1000);
    instr_valid = 1'b0;
    modelCnt    = modelCnt + CW'(1);
    check("idle", 16'(obs), 16'(idleVec(1'b0)));
    check("retire", 16'(instr_retired), 16'(modelCnt));
  endtask

  task automatic runIllegal(input logic [10:0] op);
    acceptOp(op);
    instr_valid = 1'b0;
    check("illPulse", 16'(obs), 16'(idleVec(1'b1)));
    check("illCnt", 16'(instr_retired), 16'(modelCnt));
    @(negedge clk);
    check("illDone", 16'(obs), 16'(idleVec(1'b0)));
  endtask

  task automatic pulseReset();
    #2 reset = 1'b1;
    #1;
    expQ.delete();
    phQ.delete();
    modelCnt = '0;
    instr_valid = 1'b0;
    check("rstCtl", 16'(obs), 16'(idleVec(1'b0)));
    check("rstCnt", 16'(instr_retired), 16'(modelCnt));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("postRst", 16'(obs), 16'(idleVec(1'b0)));
  endtask

  initial begin
    logic [10:0] op;
    logic [CW-1:0] startCnt;
    logic [14:0] fv;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    dmem_ready  = 1'b0;
    modelCnt    = '0;
    repeat (2) @(negedge clk);
    check("resetCtl", 16'(obs), 16'(idleVec(1'b0)));
    check("resetCnt", 16'(instr_retired), 16'(modelCnt));
    reset = 1'b0;
    @(negedge clk);

    runInstr(K_R, 0);
    runInstr(K_LD, 2);
    runInstr(K_ST, 0);
    runInstr(K_ST, 3);
    runInstr(K_CBZ, 0);
    runInstr(K_CBNZ, 0);
    runInstr(K_B, 0);
    runInstr(K_I, 0);
    runInstr(K_I, 0);
    runIllegal(11'b00000000000);
    runInstr(K_LD, TMO - 1);
    runInstr(K_LD, 0);

    // Sixteen retirements on a 4-bit counter return it to its start value.
    startCnt = modelCnt;
    for (int i = 0; i < 16; i++) runInstr(K_R, 0);
    check("wrap", 16'(instr_retired), 16'(startCnt));

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 11'($urandom); while (isLegal(op));
        runIllegal(op);
      end else begin
        runInstr($urandom_range(0, 6), $urandom_range(0, 6));
      end
    end

    // Reset while a store waits in MEM: aborted, not counted.
    runInstr(K_R, 0);
    buildSeq(K_ST, 5);
    acceptOp(makeOp(K_ST));
    runSeq(3);
    pulseReset();
    runInstr(K_R, 0);

    // Load never completes: FAULT after exactly TMO MEM cycles, sticky.
    buildSeq(K_LD, TMO);
    void'(expQ.pop_back());
    void'(phQ.pop_back());
    void'(expQ.pop_back());
    void'(phQ.pop_back());
    acceptOp(makeOp(K_LD));
    runSeq(1000);
    fv = '0;
    fv[FLT] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fault", 16'(obs), 16'(fv));
      check("faultCnt", 16'(instr_retired), 16'(modelCnt));
      instr_valid = 1'b1;
      instruction = makeOp(K_R);
      dmem_ready  = 1'($urandom);
      @(negedge clk);
    end
    pulseReset();
    runInstr(K_B, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
